// File: rtl/tag_array_l2.sv
// tag_array_l2: set-associative L2 tag store with a registered one-cycle response.
// Define TAG_L2_PLRU_EN for tree pseudo-LRU replacement; otherwise each set uses a round-robin pointer.
module tag_array_l2 #(
  parameter int INDEX_WIDTH = 10,
  parameter int TAG_WIDTH   = 18,
  parameter int NUM_WAYS    = 4,
  parameter int WAY_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [INDEX_WIDTH-1:0] req_index,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [WAY_WIDTH-1:0]   resp_way,
  output logic                   resp_dirty,
  output logic                   resp_victim_valid,
  output logic [TAG_WIDTH-1:0]   resp_victim_tag,
  output logic                   resp_victim_dirty,
  output logic                   init_done
);
  localparam int NUM_OF_SETS = 1 << INDEX_WIDTH;
`ifdef TAG_L2_PLRU_EN
  localparam int REPL_W = NUM_WAYS - 1;
`else
  localparam int REPL_W = WAY_WIDTH;
`endif
  localparam logic [INDEX_WIDTH:0] SWEEP_END = (INDEX_WIDTH + 1)'(NUM_OF_SETS);
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam logic [1:0] OP_LOOKUP    = 2'b00;
  localparam logic [1:0] OP_FILL      = 2'b01;
  localparam logic [1:0] OP_SET_DIRTY = 2'b10;
  localparam logic [1:0] OP_INVAL     = 2'b11;

  logic [TAG_WIDTH-1:0] tag_mem   [NUM_OF_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_mem [NUM_OF_SETS];
  logic [NUM_WAYS-1:0]  dirty_mem [NUM_OF_SETS];
  logic [REPL_W-1:0]    repl_mem  [NUM_OF_SETS];

  logic [0:0]             state_q, state_d;
  logic [INDEX_WIDTH:0]   sweep_q, sweep_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_hit_q, resp_hit_d;
  logic [WAY_WIDTH-1:0]   resp_way_q, resp_way_d;
  logic                   resp_dirty_q, resp_dirty_d;
  logic                   resp_victim_valid_q, resp_victim_valid_d;
  logic [TAG_WIDTH-1:0]   resp_victim_tag_q, resp_victim_tag_d;
  logic                   resp_victim_dirty_q, resp_victim_dirty_d;

  logic [NUM_WAYS-1:0]    set_valid_s, set_dirty_s, hit_vec_s, way_mask_s;
  logic [REPL_W-1:0]      set_repl_s, repl_upd_s, repl_wr_s;
  logic [WAY_WIDTH-1:0]   hit_way_s, free_way_s, pol_way_s, victim_way_s, fill_way_s;
  logic                   hit_s, set_full_s, accept_s, evict_s, repl_touch_s;
  logic                   vd_we_s, tag_we_s, repl_we_s;
  logic [INDEX_WIDTH-1:0] vd_idx_s;
  logic [NUM_WAYS-1:0]    valid_wr_s, dirty_wr_s;

  assign set_valid_s  = valid_mem[req_index];
  assign set_dirty_s  = dirty_mem[req_index];
  assign set_repl_s   = repl_mem[req_index];
  assign accept_s     = req_valid && (state_q == ST_READY);

  // Tag compare across the addressed set; the lowest matching and lowest invalid way win.
  always_comb begin
    hit_vec_s  = '0;
    hit_way_s  = '0;
    free_way_s = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec_s[w] = set_valid_s[w] && (tag_mem[req_index][w] == req_tag);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      hit_way_s  = hit_vec_s[w] ? WAY_WIDTH'(w) : hit_way_s;
      free_way_s = set_valid_s[w] ? free_way_s : WAY_WIDTH'(w);
    end
  end

  assign hit_s        = |hit_vec_s;
  assign set_full_s   = &set_valid_s;
  assign evict_s      = !hit_s && set_full_s;
  assign victim_way_s = set_full_s ? pol_way_s : free_way_s;
  assign fill_way_s   = hit_s ? hit_way_s : victim_way_s;
  assign way_mask_s   = {{(NUM_WAYS - 1){1'b0}}, 1'b1} << fill_way_s;

`ifdef TAG_L2_PLRU_EN
  // Victim: follow the tree bits from the root (bit set means go to the upper half).
  always_comb begin
    int node;
    node      = 0;
    pol_way_s = '0;
    for (int lvl = 0; lvl < WAY_WIDTH; lvl++) begin
      pol_way_s[WAY_WIDTH-1-lvl] = set_repl_s[node];
      node = 2 * node + 1 + int'(set_repl_s[node]);
    end
  end

  // Touch: every node on the path to the accessed way points to the other half.
  always_comb begin
    int node;
    node       = 0;
    repl_upd_s = set_repl_s;
    for (int lvl = 0; lvl < WAY_WIDTH; lvl++) begin
      repl_upd_s[node] = ~fill_way_s[WAY_WIDTH-1-lvl];
      node = 2 * node + 1 + int'(fill_way_s[WAY_WIDTH-1-lvl]);
    end
  end

  assign repl_touch_s = (req_op == OP_FILL) || ((req_op != OP_INVAL) && hit_s);
`else
  assign pol_way_s    = set_repl_s;
  assign repl_upd_s   = set_repl_s + REPL_W'(1'b1);
  assign repl_touch_s = (req_op == OP_FILL) && evict_s;
`endif

  // Sequencing: init sweep writes, request-driven array writes and response capture.
  always_comb begin
    state_d             = state_q;
    sweep_d             = sweep_q;
    vd_we_s             = 1'b0;
    vd_idx_s            = req_index;
    valid_wr_s          = set_valid_s;
    dirty_wr_s          = set_dirty_s;
    tag_we_s            = 1'b0;
    repl_we_s           = 1'b0;
    repl_wr_s           = repl_upd_s;
    resp_valid_d        = 1'b0;
    resp_hit_d          = 1'b0;
    resp_way_d          = '0;
    resp_dirty_d        = 1'b0;
    resp_victim_valid_d = 1'b0;
    resp_victim_tag_d   = '0;
    resp_victim_dirty_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        vd_we_s    = 1'b1;
        vd_idx_s   = sweep_q[INDEX_WIDTH-1:0];
        valid_wr_s = '0;
        dirty_wr_s = '0;
        repl_we_s  = 1'b1;
        repl_wr_s  = '0;
        sweep_d    = sweep_q + {{INDEX_WIDTH{1'b0}}, 1'b1};
        state_d    = (sweep_d == SWEEP_END) ? ST_READY : ST_INIT;
      end
      ST_READY: begin
        if (accept_s) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = hit_s;
          resp_way_d   = hit_s ? hit_way_s : '0;
          resp_dirty_d = hit_s && set_dirty_s[hit_way_s];
          repl_we_s    = repl_touch_s;
          case (req_op)
            OP_FILL: begin
              vd_we_s             = 1'b1;
              tag_we_s            = 1'b1;
              valid_wr_s          = set_valid_s | way_mask_s;
              dirty_wr_s          = set_dirty_s & ~way_mask_s;
              resp_way_d          = fill_way_s;
              resp_victim_valid_d = evict_s;
              resp_victim_tag_d   = evict_s ? tag_mem[req_index][victim_way_s] : '0;
              resp_victim_dirty_d = evict_s && set_dirty_s[victim_way_s];
            end
            OP_SET_DIRTY: begin
              vd_we_s    = hit_s;
              dirty_wr_s = set_dirty_s | way_mask_s;
            end
            OP_INVAL: begin
              vd_we_s    = hit_s;
              valid_wr_s = set_valid_s & ~way_mask_s;
              dirty_wr_s = set_dirty_s & ~way_mask_s;
            end
            default: begin
              vd_we_s = 1'b0;
            end
          endcase
        end else begin
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // Control state and response registers; rst aborts the sweep and drops any response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= ST_INIT;
      sweep_q             <= '0;
      resp_valid_q        <= 1'b0;
      resp_hit_q          <= 1'b0;
      resp_way_q          <= '0;
      resp_dirty_q        <= 1'b0;
      resp_victim_valid_q <= 1'b0;
      resp_victim_tag_q   <= '0;
      resp_victim_dirty_q <= 1'b0;
    end else begin
      state_q             <= state_d;
      sweep_q             <= sweep_d;
      resp_valid_q        <= resp_valid_d;
      resp_hit_q          <= resp_hit_d;
      resp_way_q          <= resp_way_d;
      resp_dirty_q        <= resp_dirty_d;
      resp_victim_valid_q <= resp_victim_valid_d;
      resp_victim_tag_q   <= resp_victim_tag_d;
      resp_victim_dirty_q <= resp_victim_dirty_d;
    end
  end

  // Array storage has no reset; the sweep clears valid, dirty and replacement state.
  always_ff @(posedge clk) begin
    if (vd_we_s) begin
      valid_mem[vd_idx_s] <= valid_wr_s;
      dirty_mem[vd_idx_s] <= dirty_wr_s;
    end
    if (tag_we_s) begin
      tag_mem[req_index][fill_way_s] <= req_tag;
    end
    if (repl_we_s) begin
      repl_mem[vd_idx_s] <= repl_wr_s;
    end
  end

  assign req_ready         = (state_q == ST_READY);
  assign init_done         = (state_q == ST_READY);
  assign resp_valid        = resp_valid_q;
  assign resp_hit          = resp_hit_q;
  assign resp_way          = resp_way_q;
  assign resp_dirty        = resp_dirty_q;
  assign resp_victim_valid = resp_victim_valid_q;
  assign resp_victim_tag   = resp_victim_tag_q;
  assign resp_victim_dirty = resp_victim_dirty_q;
endmodule
